// File: rtl/mips_pipe_pkg.sv
// Shared MIPS32 pipeline definitions: control-bundle layout, ALUOp codes, bubble constant
// and the ID/EX hazard FSM state encoding.
package mips_pipe_pkg;

   localparam int CTRL_W = 10;

   // Bit positions inside {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp[3:0]}
   localparam int CTRL_REGWRITE  = 9;
   localparam int CTRL_MEMTOREG  = 8;
   localparam int CTRL_MEMREAD   = 7;
   localparam int CTRL_MEMWRITE  = 6;
   localparam int CTRL_ALUSRC    = 5;
   localparam int CTRL_REGDST    = 4;
   localparam int CTRL_ALUOP_MSB = 3;
   localparam int CTRL_ALUOP_LSB = 0;

   typedef logic [CTRL_W-1:0] ctrl_t;

   localparam logic [3:0] ALUOP_ADD   = 4'h0;
   localparam logic [3:0] ALUOP_SUB   = 4'h1;
   localparam logic [3:0] ALUOP_AND   = 4'h2;
   localparam logic [3:0] ALUOP_OR    = 4'h3;
   localparam logic [3:0] ALUOP_SLT   = 4'h4;
   localparam logic [3:0] ALUOP_LUI   = 4'h5;
   localparam logic [3:0] ALUOP_RTYPE = 4'hF;

   localparam ctrl_t CTRL_BUBBLE = '0;

   localparam logic [0:0] HZ_RUN   = 1'b0;
   localparam logic [0:0] HZ_STALL = 1'b1;

   // $zero never matches: writes to it are discarded and reads are constant.
   function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/id_ex_pipe_stage_if.sv
// ID/EX stage bus: ID-side operands and control, WB bypass inputs, Stall_ID and the EX-side outputs.
interface id_ex_pipe_stage_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = mips_pipe_pkg::CTRL_W
);
   logic [DATA_W-1:0] Read_Data_1_ID;
   logic [DATA_W-1:0] Read_Data_2_ID;
   logic [DATA_W-1:0] Sign_Extend_ID;
   logic [4:0]        Rs_ID;
   logic [4:0]        Rt_ID;
   logic [4:0]        Rd_ID;
   logic              Uses_Rt_ID;
   logic [CTRL_W-1:0] Control_ID;
   logic              Flush_ID;
   logic [4:0]        Write_Register_WB;
   logic [DATA_W-1:0] Write_Data_WB;
   logic              RegWrite_WB;
   logic              Stall_ID;
   logic [DATA_W-1:0] Read_Data_1_EX;
   logic [DATA_W-1:0] Read_Data_2_EX;
   logic [DATA_W-1:0] Sign_Extend_EX;
   logic [4:0]        Rs_EX;
   logic [4:0]        Rt_EX;
   logic [4:0]        Rd_EX;
   logic [CTRL_W-1:0] Control_EX;
   logic              Valid_EX;

   modport master (
      output Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_ID, Rs_ID, Rt_ID, Rd_ID,
             Uses_Rt_ID, Control_ID, Flush_ID, Write_Register_WB, Write_Data_WB, RegWrite_WB,
      input  Stall_ID, Read_Data_1_EX, Read_Data_2_EX, Sign_Extend_EX, Rs_EX, Rt_EX, Rd_EX,
             Control_EX, Valid_EX
   );

   modport slave (
      input  Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_ID, Rs_ID, Rt_ID, Rd_ID,
             Uses_Rt_ID, Control_ID, Flush_ID, Write_Register_WB, Write_Data_WB, RegWrite_WB,
      output Stall_ID, Read_Data_1_EX, Read_Data_2_EX, Sign_Extend_EX, Rs_EX, Rt_EX, Rd_EX,
             Control_EX, Valid_EX
   );
endinterface

// File: rtl/id_ex_pipe_stage_hazard_fsm.sv
// Load-use hazard detection for the ID/EX register: compares the load in EX against the ID
// source registers and holds IF/ID for LOAD_STALL_CYCLES cycles; a branch flush overrides it.
module id_ex_hazard_fsm #(
   parameter int LOAD_STALL_CYCLES = 1
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Valid_EX_i,
   input  logic       MemRead_EX_i,
   input  logic [4:0] Rt_EX_i,
   input  logic [4:0] Rs_ID_i,
   input  logic [4:0] Rt_ID_i,
   input  logic       Uses_Rt_ID_i,
   input  logic       Flush_ID_i,
   output logic       Stall_ID_o,
   output logic       Bubble_o
);
   import mips_pipe_pkg::*;

   localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

   logic [0:0] state_d, state_q;
   logic [2:0] cnt_d, cnt_q;
   logic       hz;

   assign hz = Valid_EX_i & MemRead_EX_i &
               (reg_match(Rt_EX_i, Rs_ID_i) | (Uses_Rt_ID_i & reg_match(Rt_EX_i, Rt_ID_i)));

   // A squashed instruction can never stall, so the flush check comes first.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      Stall_ID_o = 1'b0;
      Bubble_o   = 1'b0;
      if (Flush_ID_i) begin
         Bubble_o = 1'b1;
         state_d  = HZ_RUN;
         cnt_d    = 3'd0;
      end else if (state_q == HZ_STALL) begin
         Stall_ID_o = 1'b1;
         Bubble_o   = 1'b1;
         cnt_d      = cnt_q - 3'd1;
         if (cnt_q == 3'd1) state_d = HZ_RUN;
      end else if (hz) begin
         Stall_ID_o = 1'b1;
         Bubble_o   = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            state_d = HZ_STALL;
            cnt_d   = STALL_RELOAD;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= HZ_RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion and branch flush.
// Optional WB-to-EX write-through of same-cycle register-file writes: ID_EX_WB_BYPASS_EN.
module id_ex_pipe_stage #(
   parameter int DATA_W            = 32,
   parameter int CTRL_W            = mips_pipe_pkg::CTRL_W,
   parameter int LOAD_STALL_CYCLES = 1
) (
   input logic               Clk,
   input logic               Reset_n,
   id_ex_pipe_stage_if.slave bus
);
   import mips_pipe_pkg::*;

   logic              bubble;
   logic              stall;
   logic [DATA_W-1:0] op1, op2;

   logic [DATA_W-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
   logic [4:0]        rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic              valid_d, valid_q;

   id_ex_hazard_fsm #(
      .LOAD_STALL_CYCLES(LOAD_STALL_CYCLES)
   ) u_hazard (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Valid_EX_i  (valid_q),
      .MemRead_EX_i(ctrl_q[CTRL_MEMREAD]),
      .Rt_EX_i     (rt_q),
      .Rs_ID_i     (bus.Rs_ID),
      .Rt_ID_i     (bus.Rt_ID),
      .Uses_Rt_ID_i(bus.Uses_Rt_ID),
      .Flush_ID_i  (bus.Flush_ID),
      .Stall_ID_o  (stall),
      .Bubble_o    (bubble)
   );

`ifdef ID_EX_WB_BYPASS_EN
   // The register file commits on the same edge we sample, so ID cannot see the WB write yet.
   assign op1 = (bus.RegWrite_WB && reg_match(bus.Write_Register_WB, bus.Rs_ID)) ?
                bus.Write_Data_WB : bus.Read_Data_1_ID;
   assign op2 = (bus.RegWrite_WB && reg_match(bus.Write_Register_WB, bus.Rt_ID)) ?
                bus.Write_Data_WB : bus.Read_Data_2_ID;
`else
   logic unused_wb;
   assign unused_wb = ^{bus.RegWrite_WB, bus.Write_Register_WB, bus.Write_Data_WB};
   assign op1       = bus.Read_Data_1_ID;
   assign op2       = bus.Read_Data_2_ID;
`endif

   always_comb begin
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      ctrl_d  = CTRL_W'(CTRL_BUBBLE);
      valid_d = 1'b0;
      if (!bubble) begin
         rd1_d   = op1;
         rd2_d   = op2;
         imm_d   = bus.Sign_Extend_ID;
         rs_d    = bus.Rs_ID;
         rt_d    = bus.Rt_ID;
         rd_d    = bus.Rd_ID;
         ctrl_d  = bus.Control_ID;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
      end
   end

   assign bus.Stall_ID       = stall;
   assign bus.Read_Data_1_EX = rd1_q;
   assign bus.Read_Data_2_EX = rd2_q;
   assign bus.Sign_Extend_EX = imm_q;
   assign bus.Rs_EX          = rs_q;
   assign bus.Rt_EX          = rt_q;
   assign bus.Rd_EX          = rd_q;
   assign bus.Control_EX     = ctrl_q;
   assign bus.Valid_EX       = valid_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: one instance with a single load bubble and one with three,
// driven with identical ID traffic and compared against an instruction-level reference model.
`timescale 1ns/1ps
module tb_id_ex_pipe_stage;
   import mips_pipe_pkg::*;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   id_ex_pipe_stage_if #(.DATA_W(32), .CTRL_W(10)) if1 ();
   id_ex_pipe_stage_if #(.DATA_W(32), .CTRL_W(10)) if3 ();

   id_ex_pipe_stage #(.DATA_W(32), .CTRL_W(10), .LOAD_STALL_CYCLES(1)) dut1 (
      .Clk(Clk), .Reset_n(Reset_n), .bus(if1.slave));
   id_ex_pipe_stage #(.DATA_W(32), .CTRL_W(10), .LOAD_STALL_CYCLES(3)) dut3 (
      .Clk(Clk), .Reset_n(Reset_n), .bus(if3.slave));

   int total = 0;
   int bad   = 0;

   // current ID / WB stimulus
   logic [31:0] i_d1, i_d2, i_imm, i_wd;
   logic [4:0]  i_rs, i_rt, i_rd, i_wr;
   logic        i_uses, i_flush, i_rw;
   logic [9:0]  i_ctrl;

   // reference model: what EX should hold, and pending stall cycles, per instance
   logic [31:0] m_d1[2], m_d2[2], m_imm[2];
   logic [4:0]  m_rs[2], m_rt[2], m_rd[2];
   logic [9:0]  m_ctrl[2];
   logic        m_v[2];
   int          m_rem[2];
   logic        obs_stall[2];
   logic        exp_stall[2];
   int          bubbles_per_load[2] = '{1, 3};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive();
      if1.Read_Data_1_ID = i_d1;  if3.Read_Data_1_ID = i_d1;
      if1.Read_Data_2_ID = i_d2;  if3.Read_Data_2_ID = i_d2;
      if1.Sign_Extend_ID = i_imm; if3.Sign_Extend_ID = i_imm;
      if1.Rs_ID = i_rs;           if3.Rs_ID = i_rs;
      if1.Rt_ID = i_rt;           if3.Rt_ID = i_rt;
      if1.Rd_ID = i_rd;           if3.Rd_ID = i_rd;
      if1.Uses_Rt_ID = i_uses;    if3.Uses_Rt_ID = i_uses;
      if1.Control_ID = i_ctrl;    if3.Control_ID = i_ctrl;
      if1.Flush_ID = i_flush;     if3.Flush_ID = i_flush;
      if1.Write_Register_WB = i_wr; if3.Write_Register_WB = i_wr;
      if1.Write_Data_WB = i_wd;   if3.Write_Data_WB = i_wd;
      if1.RegWrite_WB = i_rw;     if3.RegWrite_WB = i_rw;
   endtask

   task automatic set_inst(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                           input logic [9:0] ctrl, input logic flush);
      i_rs = rs; i_rt = rt; i_uses = uses; i_ctrl = ctrl; i_flush = flush;
      i_rd = 5'(rs + rt); i_d1 = $urandom; i_d2 = $urandom; i_imm = $urandom;
      i_rw = 1'b0; i_wr = 5'd0; i_wd = 32'h0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_d1[k] = 0; m_d2[k] = 0; m_imm[k] = 0; m_rs[k] = 0; m_rt[k] = 0; m_rd[k] = 0;
         m_ctrl[k] = 0; m_v[k] = 0; m_rem[k] = 0;
      end
   endtask

   task automatic check_ex(input int k);
      string t;
      t = (k == 0) ? "L1" : "L3";
      if (k == 0) begin
         chk({t, ".rd1"}, if1.Read_Data_1_EX, m_d1[k]);
         chk({t, ".rd2"}, if1.Read_Data_2_EX, m_d2[k]);
         chk({t, ".imm"}, if1.Sign_Extend_EX, m_imm[k]);
         chk({t, ".regs"}, {if1.Rs_EX, if1.Rt_EX, if1.Rd_EX}, {m_rs[k], m_rt[k], m_rd[k]});
         chk({t, ".ctrl"}, if1.Control_EX, m_ctrl[k]);
         chk({t, ".valid"}, if1.Valid_EX, m_v[k]);
      end else begin
         chk({t, ".rd1"}, if3.Read_Data_1_EX, m_d1[k]);
         chk({t, ".rd2"}, if3.Read_Data_2_EX, m_d2[k]);
         chk({t, ".imm"}, if3.Sign_Extend_EX, m_imm[k]);
         chk({t, ".regs"}, {if3.Rs_EX, if3.Rt_EX, if3.Rd_EX}, {m_rs[k], m_rt[k], m_rd[k]});
         chk({t, ".ctrl"}, if3.Control_EX, m_ctrl[k]);
         chk({t, ".valid"}, if3.Valid_EX, m_v[k]);
      end
   endtask

   // One ID cycle: drive, check the stall decision, clock, check what EX captured.
   task automatic step();
      logic        hz, load;
      logic [31:0] op1, op2;
      drive();
      #1;
      obs_stall[0] = if1.Stall_ID;
      obs_stall[1] = if3.Stall_ID;
      op1 = i_d1;
      op2 = i_d2;
`ifdef ID_EX_WB_BYPASS_EN
      if (i_rw && i_wr != 0 && i_wr == i_rs) op1 = i_wd;
      if (i_rw && i_wr != 0 && i_wr == i_rt) op2 = i_wd;
`endif
      for (int k = 0; k < 2; k++) begin
         hz = m_v[k] && m_ctrl[k][CTRL_MEMREAD] && m_rt[k] != 0 &&
              (m_rt[k] == i_rs || (i_uses && m_rt[k] == i_rt));
         load = 1'b0;
         exp_stall[k] = 1'b0;
         if (i_flush) begin
            m_rem[k] = 0;
         end else if (m_rem[k] > 0) begin
            exp_stall[k] = 1'b1;
            m_rem[k]--;
         end else if (hz) begin
            exp_stall[k] = 1'b1;
            m_rem[k] = bubbles_per_load[k] - 1;
         end else begin
            load = 1'b1;
         end
         chk((k == 0) ? "L1.stall" : "L3.stall", obs_stall[k], exp_stall[k]);
         m_d1[k]   = load ? op1 : 32'h0;
         m_d2[k]   = load ? op2 : 32'h0;
         m_imm[k]  = load ? i_imm : 32'h0;
         m_rs[k]   = load ? i_rs : 5'd0;
         m_rt[k]   = load ? i_rt : 5'd0;
         m_rd[k]   = load ? i_rd : 5'd0;
         m_ctrl[k] = load ? i_ctrl : 10'h0;
         m_v[k]    = load;
      end
      @(posedge Clk);
      #1;
      check_ex(0);
      check_ex(1);
   endtask

   // Pulls reset mid-cycle and checks the asynchronous clear before any edge.
   task automatic mid_cycle_reset(input string tag);
      #3;
      Reset_n = 1'b0;
      #1;
      model_reset();
      chk({tag, ".stall1"}, if1.Stall_ID, 1'b0);
      chk({tag, ".stall3"}, if3.Stall_ID, 1'b0);
      check_ex(0);
      check_ex(1);
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0: return 5'd0;
         1: return 5'd8;
         2: return 5'd5;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   int cnt1, cnt3;

   initial begin
      Reset_n = 1'b0;
      set_inst(5'd0, 5'd0, 1'b0, 10'h0, 1'b0);
      drive();
      model_reset();
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      check_ex(0);
      check_ex(1);

      // pass-through
      set_inst(5'd3, 5'd4, 1'b0, 10'h2A5, 1'b0);
      i_d1 = 32'h1234_5678;
      step();
      chk("pass.rd1", if1.Read_Data_1_EX, 32'h1234_5678);
      chk("pass.ctrl", if1.Control_EX, 32'h2A5);
      chk("pass.valid", if3.Valid_EX, 1'b1);

      mid_cycle_reset("rst_mid");

      // load-use: lw $8, then a consumer of $8 held in ID while stalled
      set_inst(5'd1, 5'd8, 1'b0, 10'h2A0, 1'b0);
      step();
      cnt1 = 0; cnt3 = 0;
      for (int n = 0; n < 5; n++) begin
         set_inst(5'd8, 5'd9, 1'b1, 10'h20F, 1'b0);
         step();
         cnt1 += int'(obs_stall[0]);
         cnt3 += int'(obs_stall[1]);
      end
      chk("lu.bubbles1", cnt1, 1);
      chk("lu.bubbles3", cnt3, 3);
      chk("lu.captured", if3.Valid_EX, 1'b1);

      // no false hazard: $zero load target, and rt match without a rt read
      set_inst(5'd1, 5'd0, 1'b0, 10'h2A0, 1'b0);
      step();
      set_inst(5'd0, 5'd0, 1'b1, 10'h20F, 1'b0);
      step();
      chk("nofalse.zero", obs_stall[1], 1'b0);
      set_inst(5'd0, 5'd8, 1'b0, 10'h2A0, 1'b0);
      step();
      set_inst(5'd1, 5'd8, 1'b0, 10'h20F, 1'b0);
      step();
      chk("nofalse.uses", obs_stall[0], 1'b0);

      // flush beats a hazard raised in the same cycle
      set_inst(5'd0, 5'd8, 1'b0, 10'h2A0, 1'b0);
      step();
      set_inst(5'd8, 5'd1, 1'b0, 10'h20F, 1'b1);
      step();
      chk("flush.nostall", obs_stall[1], 1'b0);
      chk("flush.bubble", if3.Valid_EX, 1'b0);

      // flush while in the extended stall returns to RUN
      set_inst(5'd0, 5'd8, 1'b0, 10'h2A0, 1'b0);
      step();
      set_inst(5'd8, 5'd1, 1'b0, 10'h20F, 1'b0);
      step();
      chk("flushst.stalled", obs_stall[1], 1'b1);
      set_inst(5'd8, 5'd1, 1'b0, 10'h20F, 1'b1);
      step();
      chk("flushst.release", obs_stall[1], 1'b0);
      set_inst(5'd2, 5'd1, 1'b0, 10'h20F, 1'b0);
      step();
      chk("flushst.run", obs_stall[1], 1'b0);
      chk("flushst.valid", if3.Valid_EX, 1'b1);

      // same-cycle WB write to the rt register
      set_inst(5'd6, 5'd5, 1'b1, 10'h20F, 1'b0);
      i_d2 = 32'h0; i_rw = 1'b1; i_wr = 5'd5; i_wd = 32'hCAFE_0001;
      step();
`ifdef ID_EX_WB_BYPASS_EN
      chk("bypass.rd2", if1.Read_Data_2_EX, 32'hCAFE_0001);
`else
      chk("bypass.rd2", if1.Read_Data_2_EX, 32'h0);
`endif

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         i_rs = pick_reg(); i_rt = pick_reg(); i_rd = 5'($urandom);
         i_uses = 1'($urandom); i_flush = ($urandom_range(0, 7) == 0);
         i_ctrl = 10'($urandom);
         i_d1 = $urandom; i_d2 = $urandom; i_imm = $urandom;
         i_rw = 1'($urandom); i_wr = pick_reg(); i_wd = $urandom;
         step();
      end

      // reset while the three-bubble instance sits in its extended stall
      set_inst(5'd0, 5'd0, 1'b0, 10'h0, 1'b1);
      step();
      set_inst(5'd0, 5'd8, 1'b0, 10'h2A0, 1'b0);
      step();
      set_inst(5'd8, 5'd1, 1'b0, 10'h20F, 1'b0);
      step();
      drive();
      #1;
      chk("rststall.pre", if3.Stall_ID, 1'b1);
      mid_cycle_reset("rststall");
      set_inst(5'd8, 5'd1, 1'b0, 10'h20F, 1'b0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
